// File: rtl/uart_tx.sv
// UART transmitter: 16x oversampled bit timing, 5-8 data bits, optional
// parity (odd/even/stick), 1 or 2 stop bits and break control.
module uart_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic [7:0] thr_data,
    input  logic       thr_valid,
    output logic       thr_ready,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       brk,
    output logic       txd,
    output logic       tx_busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0] state_r;
    logic [2:0] state_s;
    logic [3:0] tick_r;
    logic [3:0] tick_s;
    logic [2:0] bit_r;
    logic [2:0] bit_s;
    logic [7:0] data_r;
    logic [1:0] wls_r;
    logic       stb_r;
    logic       pen_r;
    logic       eps_r;
    logic       sp_r;
    logic       txd_r;
    logic       line_s;
    logic       par_s;
    logic [2:0] last_bit_s;

    // Bits above the word length are masked so the result equals the XOR of
    // the zero-extended character seen by the receiver.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] len,
                                        input logic even, input logic stick);
        logic [7:0] mask;
        logic       p;
        mask = 8'hFF >> (2'd3 - len);
        p    = ^(data & mask);
        if (stick) begin
            parity_bit = ~even;
        end else if (even) begin
            parity_bit = p;
        end else begin
            parity_bit = ~p;
        end
    endfunction

    assign last_bit_s = 3'd4 + {1'b0, wls_r};
    assign par_s      = parity_bit(data_r, wls_r, eps_r, sp_r);

    // Next-state logic: every bit period is 16 ticks; STOP reuses bit_r to count a second stop bit.
    always_comb begin
        state_s = state_r;
        tick_s  = tick_r;
        bit_s   = bit_r;
        case (state_r)
            IDLE: begin
                if (thr_valid) begin
                    state_s = START;
                    tick_s  = 4'd0;
                    bit_s   = 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            START, DATA, PARITY, STOP: begin
                if (baud_tick) begin
                    tick_s = tick_r + 4'd1;
                    if (tick_r == 4'd15) begin
                        case (state_r)
                            START: begin
                                state_s = DATA;
                                bit_s   = 3'd0;
                            end
                            DATA: begin
                                if (bit_r == last_bit_s) begin
                                    state_s = pen_r ? PARITY : STOP;
                                    bit_s   = 3'd0;
                                end else begin
                                    bit_s = bit_r + 3'd1;
                                end
                            end
                            PARITY: begin
                                state_s = STOP;
                                bit_s   = 3'd0;
                            end
                            STOP: begin
                                if (stb_r && (bit_r == 3'd0)) begin
                                    bit_s = 3'd1;
                                end else begin
                                    state_s = IDLE;
                                    bit_s   = 3'd0;
                                end
                            end
                            default: state_s = IDLE;
                        endcase
                    end else begin
                        bit_s = bit_r;
                    end
                end else begin
                    tick_s = tick_r;
                end
            end
            default: begin
                state_s = IDLE;
                tick_s  = 4'd0;
                bit_s   = 3'd0;
            end
        endcase
    end

    // Line level for the upcoming state, so txd can be registered without a cycle of lag.
    always_comb begin
        case (state_s)
            IDLE:    line_s = 1'b1;
            START:   line_s = 1'b0;
            DATA:    line_s = data_r[bit_s];
            PARITY:  line_s = par_s;
            STOP:    line_s = 1'b1;
            default: line_s = 1'b1;
        endcase
    end

    // State, counters, frame configuration latch and registered serial output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            tick_r  <= 4'd0;
            bit_r   <= 3'd0;
            data_r  <= 8'd0;
            wls_r   <= 2'd0;
            stb_r   <= 1'b0;
            pen_r   <= 1'b0;
            eps_r   <= 1'b0;
            sp_r    <= 1'b0;
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            bit_r   <= bit_s;
            if ((state_r == IDLE) && thr_valid) begin
                data_r <= thr_data;
                wls_r  <= wls;
                stb_r  <= stb;
                pen_r  <= pen;
                eps_r  <= eps;
                sp_r   <= sp;
            end else begin
                data_r <= data_r;
            end
            txd_r <= brk ? 1'b0 : line_s;
        end
    end

    assign thr_ready = (state_r == IDLE);
    assign tx_busy   = (state_r != IDLE);
    assign txd       = txd_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a tick-count frame model predicts txd,
// tx_busy and thr_ready every cycle under directed and randomized stimulus.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic [7:0] thr_data;
    logic       thr_valid;
    logic       thr_ready;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       brk;
    logic       txd;
    logic       tx_busy;

    int tests = 0;
    int fails = 0;

    int tick_mode = 0;
    bit scramble  = 1'b0;
    bit rand_brk  = 1'b0;

    // Reference model: a frame is a list of line levels, each held for 16 ticks.
    bit m_busy    = 1'b0;
    bit m_brk     = 1'b0;
    int m_cnt     = 0;
    int m_nbits   = 0;
    int m_accepts = 0;
    bit m_bits [0:11];

    uart_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .thr_data  (thr_data),
        .thr_valid (thr_valid),
        .thr_ready (thr_ready),
        .wls       (wls),
        .stb       (stb),
        .pen       (pen),
        .eps       (eps),
        .sp        (sp),
        .brk       (brk),
        .txd       (txd),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int nd;
        int k;
        bit p;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_brk  = 1'b0;
        end else begin
            m_brk = brk;
            if (!m_busy) begin
                if (thr_valid) begin
                    nd = 5 + int'(wls);
                    p  = 1'b0;
                    m_bits[0] = 1'b0;
                    for (int i = 0; i < nd; i++) begin
                        m_bits[1 + i] = thr_data[i];
                        p ^= thr_data[i];
                    end
                    k = 1 + nd;
                    if (pen) begin
                        m_bits[k] = sp ? !eps : (eps ? p : !p);
                        k++;
                    end
                    m_bits[k] = 1'b1;
                    k++;
                    if (stb) begin
                        m_bits[k] = 1'b1;
                        k++;
                    end
                    m_nbits = k;
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    m_accepts++;
                end
            end else if (baud_tick) begin
                m_cnt++;
                if (m_cnt == m_nbits * 16) m_busy = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic exp_txd;
        if (tick_mode == 0) baud_tick = 1'b1;
        else baud_tick = ($urandom_range(0, 2) == 0);
        if (scramble && m_busy) begin
            thr_data = 8'($urandom_range(0, 255));
            wls      = 2'($urandom_range(0, 3));
            stb      = 1'($urandom_range(0, 1));
            pen      = 1'($urandom_range(0, 1));
            eps      = 1'($urandom_range(0, 1));
            sp       = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_txd = m_brk ? 1'b0 : (m_busy ? m_bits[m_cnt / 16] : 1'b1);
        check("txd", txd, exp_txd);
        check("tx_busy", tx_busy, m_busy);
        check("thr_ready", thr_ready, !m_busy);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [1:0] w, input logic s,
                             input logic p, input logic e, input logic spv,
                             input int brk_at, input int brk_len, input int rst_at,
                             output int busy_cycles);
        int guard;
        thr_data  = d;
        wls       = w;
        stb       = s;
        pen       = p;
        eps       = e;
        sp        = spv;
        brk       = 1'b0;
        thr_valid = 1'b1;
        busy_cycles = 0;
        guard       = 0;
        step();
        thr_valid = 1'b0;
        while (m_busy && guard < 4000) begin
            if (tx_busy) busy_cycles++;
            if (rand_brk) brk = ($urandom_range(0, 15) == 0);
            else brk = (brk_at >= 0) && (m_cnt >= brk_at) && (m_cnt < brk_at + brk_len);
            if ((rst_at >= 0) && (m_cnt == rst_at)) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            guard++;
        end
        brk = 1'b0;
        check("frame_timeout", guard < 4000, 1'b1);
    endtask

    initial begin
        int bc;
        int acc0;
        int ready_hi;
        int guard;

        rst_n     = 1'b0;
        baud_tick = 1'b0;
        thr_data  = 8'h00;
        thr_valid = 1'b0;
        wls       = 2'b00;
        stb       = 1'b0;
        pen       = 1'b0;
        eps       = 1'b0;
        sp        = 1'b0;
        brk       = 1'b0;

        // Reset state, even with a request and break pending.
        step();
        thr_valid = 1'b1;
        brk       = 1'b1;
        step();
        thr_valid = 1'b0;
        brk       = 1'b0;
        rst_n     = 1'b1;
        step();
        step();

        // 0x55, 8N1, continuous ticks: 160 busy cycles.
        tick_mode = 0;
        run_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1, bc);
        check("busy_160", bc == 160, 1'b1);
        step();

        // 0x07 with every parity flavour.
        run_frame(8'h07, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1, bc);
        run_frame(8'h07, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0, -1, bc);
        run_frame(8'h07, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, -1, bc);
        run_frame(8'h07, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0, -1, bc);

        // 0xFF, 5 data bits, even parity, one then two stop bits.
        run_frame(8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, -1, bc);
        check("busy_5e1", bc == 8 * 16, 1'b1);
        run_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0, -1, bc);
        check("busy_5e2", bc == 9 * 16, 1'b1);

        // Back-to-back 0xA5 then 0x3C with thr_valid held high.
        acc0      = m_accepts;
        thr_data  = 8'hA5;
        wls       = 2'b11;
        stb       = 1'b0;
        pen       = 1'b0;
        thr_valid = 1'b1;
        step();
        thr_data  = 8'h3C;
        ready_hi  = 0;
        guard     = 0;
        while (m_accepts < acc0 + 2 && guard < 1000) begin
            step();
            if (thr_ready) ready_hi++;
            guard++;
        end
        check("b2b_ready_pulse", ready_hi == 1, 1'b1);
        thr_valid = 1'b0;
        guard     = 0;
        while (m_busy && guard < 1000) begin
            step();
            guard++;
        end
        check("b2b_timeout", guard < 1000, 1'b1);

        // Break for 20 ticks inside the data bits of 0xFF; frame length unchanged.
        run_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3 * 16, 20, -1, bc);
        check("brk_len", bc == 160, 1'b1);

        // Reset in the parity bit, then a clean frame.
        run_frame(8'h07, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 9 * 16 + 5, bc);
        check("rst_abort", bc == 9 * 16 + 5 + 1, 1'b1);
        step();
        run_frame(8'h5A, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0, -1, bc);

        // Randomized frames with sparse ticks, mid-frame input churn and break glitches.
        for (int i = 0; i < 8; i++) begin
            tick_mode = i % 2;
            scramble  = 1'b1;
            rand_brk  = (i >= 4);
            run_frame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      -1, 0, -1, bc);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
